// File: rtl/tl_d_responder.sv
// tl_d_responder: TileLink-UL/UH slave stub returning in-order D responses after a programmable latency.
// Optional address deny window is compiled in when TL_RESPONDER_DENY_WINDOW_EN is defined.
module tl_d_responder #(
  parameter int SOURCE_W = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 4,
  parameter int LATENCY  = 2,
  parameter int MAX_SIZE = 6
`ifdef TL_RESPONDER_DENY_WINDOW_EN
  ,
  parameter logic [ADDR_W-1:0] WIN_BASE = '0,
  parameter logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(32'h0000_FFFF)
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                d_corrupt
);
  localparam int BEAT_LG = $clog2(DATA_W / 8);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam logic [2:0]       BEAT_LG3  = 3'(BEAT_LG);
  localparam logic [2:0]       MAX_SIZE3 = 3'(MAX_SIZE);
  localparam logic [3:0]       LAT4      = 4'(LATENCY);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [ADDR_W-1:0]   base;
  } entry_t;

  function automatic logic [7:0] beats_of(input logic [2:0] size);
    logic [7:0] n;
    n = 8'd1;
    if (size > BEAT_LG3) n = 8'd1 << (size - BEAT_LG3);
    return n;
  endfunction

  function automatic logic [2:0] rsp_opcode(input logic [2:0] op);
    logic [2:0] r;
    case (op)
      3'd4:    r = 3'd1;
      3'd5:    r = 3'd2;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic deny_opcode(input logic [2:0] op);
    return !(op inside {3'd0, 3'd1, 3'd4, 3'd5});
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] base,
                                                  input logic [7:0] k);
    logic [ADDR_W-1:0] addr;
    addr = base + (ADDR_W'(k) << BEAT_LG);
    return DATA_W'(addr);
  endfunction

  logic [7:0]          a_beat;
  logic [2:0]          hdr_opcode, hdr_size;
  logic [SOURCE_W-1:0] hdr_source;
  logic [ADDR_W-1:0]   hdr_address;
  logic                a_fire, a_first, a_last, push;
  logic [2:0]          sel_opcode, sel_size;
  logic [SOURCE_W-1:0] sel_source;
  logic [ADDR_W-1:0]   sel_address;
  logic [7:0]          a_total;
  logic                win_deny;
  entry_t              push_entry;

  entry_t              mem [DEPTH];
  logic [3:0]          countdown [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic [7:0]          d_beat, d_total;
  logic                d_fire, pop;
  entry_t              head;
  logic                unused_a_data;

  assign unused_a_data = ^a_data;

  // A side: header comes from the bus on the first beat, from the capture regs afterwards
  assign a_ready     = !reset && (count < DEPTH_C);
  assign a_fire      = a_valid && a_ready;
  assign a_first     = (a_beat == 8'd0);
  assign sel_opcode  = a_first ? a_opcode  : hdr_opcode;
  assign sel_size    = a_first ? a_size    : hdr_size;
  assign sel_source  = a_first ? a_source  : hdr_source;
  assign sel_address = a_first ? a_address : hdr_address;
  assign a_total     = (sel_opcode == 3'd0 || sel_opcode == 3'd1) ? beats_of(sel_size) : 8'd1;
  assign a_last      = (a_beat == a_total - 8'd1);
  assign push        = a_fire && a_last;

`ifdef TL_RESPONDER_DENY_WINDOW_EN
  assign win_deny = ((sel_address & ~WIN_MASK) != WIN_BASE);
`else
  assign win_deny = 1'b0;
`endif

  always_comb begin
    push_entry        = '0;
    push_entry.opcode = rsp_opcode(sel_opcode);
    push_entry.size   = sel_size;
    push_entry.source = sel_source;
    push_entry.denied = deny_opcode(sel_opcode) | (sel_size > MAX_SIZE3) | win_deny;
    push_entry.base   = sel_address & ~((ADDR_W'(1) << sel_size) - ADDR_W'(1));
  end

  // D side: head entry is visible only once its countdown has expired
  assign head      = mem[rd_ptr];
  assign d_total   = (head.opcode == 3'd1) ? beats_of(head.size) : 8'd1;
  assign d_valid   = !reset && (count != '0) && (countdown[rd_ptr] == 4'd0);
  assign d_fire    = d_valid && d_ready;
  assign pop       = d_fire && (d_beat == d_total - 8'd1);
  assign d_opcode  = d_valid ? head.opcode : 3'd0;
  assign d_size    = d_valid ? head.size   : 3'd0;
  assign d_source  = d_valid ? head.source : '0;
  assign d_denied  = d_valid ? head.denied : 1'b0;
  assign d_data    = (d_valid && head.opcode == 3'd1 && !head.denied) ?
                     beat_data(head.base, d_beat) : '0;
  assign d_corrupt = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_beat <= '0;
      d_beat <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) countdown[i] <= '0;
    end else begin
      if (a_fire) a_beat <= a_last ? 8'd0 : a_beat + 8'd1;
      if (d_fire) d_beat <= pop ? 8'd0 : d_beat + 8'd1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i))  countdown[i] <= LAT4;
        else if (countdown[i] != 4'd0)    countdown[i] <= countdown[i] - 4'd1;
      end
    end
  end

  // Payload storage carries no reset; it is only observed through a valid head
  always_ff @(posedge clock) begin
    if (a_fire && a_first) begin
      hdr_opcode  <= a_opcode;
      hdr_size    <= a_size;
      hdr_source  <= a_source;
      hdr_address <= a_address;
    end
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_tl_d_responder.sv
// tb_tl_d_responder: vector table, hand sequences and random traffic against a queue-based response model.
module tb_tl_d_responder;
  localparam int SOURCE_W = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 4;
  localparam int LATENCY  = 2;
  localparam int MAX_SIZE = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               a_valid, a_ready, d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]         a_opcode, a_size, d_opcode, d_size;
  logic [SOURCE_W-1:0] a_source, d_source;
  logic [ADDR_W-1:0]  a_address;
  logic [DATA_W-1:0]  a_data, d_data;

  always #5 clock = ~clock;

  tl_d_responder #(
    .SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DEPTH(DEPTH), .LATENCY(LATENCY), .MAX_SIZE(MAX_SIZE)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    bit          denied;
    logic [63:0] base;
    int          nbeats;
    int          beat;
    longint      ready;
  } rsp_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [2:0]  e_op;
    logic        e_den;
    int          e_beats;
    logic [63:0] e_data0;
    logic [63:0] e_step;
  } vec_t;

  rsp_t        q[$];
  beat_t       obs[$];
  rsp_t        m_r;
  bit          m_ar, m_dv, a_in_burst;
  int          a_seen, a_total;
  logic [2:0]  h_op, h_size;
  logic [3:0]  h_src;
  logic [31:0] h_addr;
  logic [63:0] m_ed, held;
  bit          prev, rnd_done;
  logic [2:0]  r_op, r_size;
  vec_t        vt[12];

  function automatic int n_beats(input int size);
    return (size > 3) ? (1 << (size - 3)) : 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: one queue of pending responses, each stamped with its earliest issue cycle
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_d_valid", 64'(d_valid), 64'd0);
      chk("rst_d_fields", 64'({d_opcode, d_size, d_source, d_denied}), 64'd0);
      chk("rst_d_data", d_data, 64'd0);
      q.delete();
      a_in_burst = 1'b0;
      a_seen     = 0;
    end else begin
      m_ar = (q.size() < DEPTH);
      chk("a_ready", 64'(a_ready), 64'(m_ar));
      m_dv = (q.size() != 0) && (cyc >= q[0].ready);
      chk("d_valid", 64'(d_valid), 64'(m_dv));
      if (m_dv) begin
        m_ed = (q[0].op == 3'd1 && !q[0].denied) ? q[0].base + 64'(q[0].beat) * 64'd8 : 64'd0;
        chk("d_opcode", 64'(d_opcode), 64'(q[0].op));
        chk("d_size", 64'(d_size), 64'(q[0].size));
        chk("d_source", 64'(d_source), 64'(q[0].src));
        chk("d_denied", 64'(d_denied), 64'(q[0].denied));
        chk("d_data", d_data, m_ed);
        chk("d_corrupt", 64'(d_corrupt), 64'd0);
        if (d_ready) begin
          obs.push_back('{d_opcode, d_size, d_source, d_denied, d_data});
          q[0].beat = q[0].beat + 1;
          if (q[0].beat == q[0].nbeats) void'(q.pop_front());
        end
      end
      if (a_valid && m_ar) begin
        if (!a_in_burst) begin
          h_op = a_opcode; h_size = a_size; h_src = a_source; h_addr = a_address;
          a_total    = (a_opcode <= 3'd1) ? n_beats(int'(a_size)) : 1;
          a_seen     = 0;
          a_in_burst = 1'b1;
        end
        a_seen++;
        if (a_seen == a_total) begin
          m_r.op     = (h_op == 3'd4) ? 3'd1 : (h_op == 3'd5) ? 3'd2 : 3'd0;
          m_r.denied = !(h_op == 3'd0 || h_op == 3'd1 || h_op == 3'd4 || h_op == 3'd5) ||
                       (int'(h_size) > MAX_SIZE);
          m_r.size   = h_size;
          m_r.src    = h_src;
          m_r.base   = {32'd0, h_addr} & ~((64'd1 << h_size) - 64'd1);
          m_r.nbeats = (h_op == 3'd4) ? n_beats(int'(h_size)) : 1;
          m_r.beat   = 0;
          m_r.ready  = cyc + 1 + LATENCY;
          q.push_back(m_r);
          a_in_burst = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic send_beat(input logic [2:0] op, input logic [2:0] size,
                           input logic [3:0] src, input logic [31:0] addr);
    bit ok;
    ok = 1'b0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src; a_address = addr;
    a_data  = {$urandom, $urandom};
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clock);
      ok = a_ready;
      tick();
    end
    chk("a_beat_accepted", 64'(ok), 64'd1);
    a_valid = 1'b0;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [2:0] size,
                          input logic [3:0] src, input logic [31:0] addr);
    int nb;
    nb = (op <= 3'd1) ? n_beats(int'(size)) : 1;
    send_beat(op, size, src, addr);
    for (int b = 1; b < nb; b++)
      send_beat(3'($urandom), 3'($urandom), 4'($urandom), $urandom);
  endtask

  task automatic wait_obs(input int n, input string name);
    int k;
    k = 0;
    while (obs.size() < n && k < 600) begin
      tick();
      k++;
    end
    chk(name, 64'(obs.size() >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0; a_data = 0;
    d_ready = 0; reset = 1;
    repeat (3) tick();
    reset = 0;
    @(negedge clock);
    chk("post_rst_a_ready", 64'(a_ready), 64'd1);
    chk("post_rst_d_valid", 64'(d_valid), 64'd0);
    tick();

    // First-response latency: fire at T, visible at T+1+LATENCY
    d_ready = 1;
    obs.delete();
    send_beat(3'd4, 3'd3, 4'd5, 32'h100);
    @(negedge clock); chk("lat_T1_d_valid", 64'(d_valid), 64'd0); tick();
    @(negedge clock); chk("lat_T2_d_valid", 64'(d_valid), 64'd0); tick();
    @(negedge clock);
    chk("lat_T3_d_valid", 64'(d_valid), 64'd1);
    chk("lat_d_opcode", 64'(d_opcode), 64'd1);
    chk("lat_d_size", 64'(d_size), 64'd3);
    chk("lat_d_source", 64'(d_source), 64'd5);
    chk("lat_d_data", d_data, 64'h100);
    chk("lat_a_ready", 64'(a_ready), 64'd1);
    tick();
    @(negedge clock); chk("lat_single_beat", 64'(d_valid), 64'd0); tick();

    vt[0]  = '{3'd4, 3'd2, 4'd1,  32'h37,   3'd1, 1'b0, 1,  64'h34,   64'd0};
    vt[1]  = '{3'd5, 3'd2, 4'd2,  32'h44,   3'd2, 1'b0, 1,  64'h0,    64'd0};
    vt[2]  = '{3'd1, 3'd2, 4'd3,  32'h10,   3'd0, 1'b0, 1,  64'h0,    64'd0};
    vt[3]  = '{3'd6, 3'd2, 4'd7,  32'h20,   3'd0, 1'b1, 1,  64'h0,    64'd0};
    vt[4]  = '{3'd2, 3'd3, 4'd8,  32'h28,   3'd0, 1'b1, 1,  64'h0,    64'd0};
    vt[5]  = '{3'd4, 3'd7, 4'd9,  32'h1234, 3'd1, 1'b1, 16, 64'h0,    64'd0};
    vt[6]  = '{3'd4, 3'd4, 4'd11, 32'h1018, 3'd1, 1'b0, 2,  64'h1010, 64'd8};
    vt[7]  = '{3'd0, 3'd6, 4'd12, 32'h80,   3'd0, 1'b0, 1,  64'h0,    64'd0};
    vt[8]  = '{3'd4, 3'd6, 4'd13, 32'hABCD, 3'd1, 1'b0, 8,  64'hABC0, 64'd8};
    vt[9]  = '{3'd5, 3'd7, 4'd14, 32'h400,  3'd2, 1'b1, 1,  64'h0,    64'd0};
    vt[10] = '{3'd3, 3'd0, 4'd6,  32'h3,    3'd0, 1'b1, 1,  64'h0,    64'd0};
    vt[11] = '{3'd0, 3'd7, 4'd15, 32'h900,  3'd0, 1'b1, 1,  64'h0,    64'd0};
    d_ready = 1;
    for (int i = 0; i < 12; i++) begin
      obs.delete();
      send_req(vt[i].op, vt[i].size, vt[i].src, vt[i].addr);
      wait_obs(vt[i].e_beats, $sformatf("vec%0d_done", i));
      repeat (LATENCY + 3) tick();
      chk($sformatf("vec%0d_beats", i), 64'(obs.size()), 64'(vt[i].e_beats));
      if (obs.size() > 0) begin
        chk($sformatf("vec%0d_opcode", i), 64'(obs[0].op), 64'(vt[i].e_op));
        chk($sformatf("vec%0d_size", i), 64'(obs[0].size), 64'(vt[i].size));
        chk($sformatf("vec%0d_source", i), 64'(obs[0].src), 64'(vt[i].src));
      end
      for (int k = 0; k < obs.size(); k++) begin
        chk($sformatf("vec%0d_denied_b%0d", i, k), 64'(obs[k].den), 64'(vt[i].e_den));
        chk($sformatf("vec%0d_data_b%0d", i, k), obs[k].data,
            vt[i].e_data0 + 64'(k) * vt[i].e_step);
      end
    end

    // Multi-beat data response under a toggling d_ready
    obs.delete();
    send_beat(3'd4, 3'd5, 4'd6, 32'h208);
    prev = 1'b0;
    for (int n = 0; n < 80 && obs.size() < 4; n++) begin
      d_ready = ((n % 2) == 1);
      @(negedge clock);
      if (prev) begin
        chk("stall_d_valid_held", 64'(d_valid), 64'd1);
        chk("stall_d_data_held", d_data, held);
      end
      prev = d_valid && !d_ready;
      held = d_data;
      tick();
    end
    d_ready = 1;
    chk("stall_beats", 64'(obs.size()), 64'd4);
    for (int k = 0; k < obs.size() && k < 4; k++)
      chk($sformatf("stall_data_b%0d", k), obs[k].data, 64'h200 + 64'(k) * 64'd8);
    @(negedge clock); chk("stall_popped", 64'(d_valid), 64'd0); tick();

    // PutFull burst: nothing on D until the last A beat
    obs.delete();
    send_beat(3'd0, 3'd4, 4'd3, 32'h40);
    repeat (4) begin
      @(negedge clock); chk("put_no_early_d", 64'(d_valid), 64'd0); tick();
    end
    send_beat(3'd6, 3'd1, 4'd9, 32'hDEAD);
    wait_obs(1, "put_rsp");
    repeat (4) tick();
    chk("put_rsp_count", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) begin
      chk("put_opcode", 64'(obs[0].op), 64'd0);
      chk("put_source", 64'(obs[0].src), 64'd3);
      chk("put_denied", 64'(obs[0].den), 64'd0);
    end

    // Fill the queue with d_ready low, then drain
    obs.delete();
    d_ready = 0;
    for (int i = 0; i < 4; i++) send_beat(3'd4, 3'd3, 4'(i), 32'(i * 64));
    a_valid = 1; a_opcode = 3'd4; a_size = 3'd3; a_source = 4'd4; a_address = 32'h100;
    repeat (3) begin
      @(negedge clock); chk("full_a_ready", 64'(a_ready), 64'd0); tick();
    end
    d_ready = 1;
    @(negedge clock);
    chk("full_pop_cycle_a_ready", 64'(a_ready), 64'd0);
    chk("full_head_valid", 64'(d_valid), 64'd1);
    tick();
    @(negedge clock); chk("full_a_ready_back", 64'(a_ready), 64'd1); tick();
    a_valid = 0;
    wait_obs(5, "full_drain");
    repeat (4) tick();
    chk("full_rsp_count", 64'(obs.size()), 64'd5);
    for (int i = 0; i < obs.size() && i < 5; i++)
      chk($sformatf("full_order_%0d", i), 64'(obs[i].src), 64'(i));

    // Reset in the middle of a 4-beat D burst
    obs.delete();
    send_beat(3'd4, 3'd5, 4'hA, 32'h300);
    for (int k = 0; k < 50 && obs.size() < 2; k++) tick();
    reset = 1;
    @(negedge clock);
    chk("rst_mid_d_valid", 64'(d_valid), 64'd0);
    chk("rst_mid_a_ready", 64'(a_ready), 64'd0);
    tick();
    @(negedge clock); chk("rst_hold_d_valid", 64'(d_valid), 64'd0); tick();
    reset = 0;
    @(negedge clock);
    chk("rst_release_a_ready", 64'(a_ready), 64'd1);
    chk("rst_release_d_valid", 64'(d_valid), 64'd0);
    tick();
    chk("rst_mid_beats_seen", 64'(obs.size()), 64'd2);
    obs.delete();
    send_beat(3'd4, 3'd3, 4'hB, 32'h408);
    wait_obs(1, "rst_new_get");
    repeat (4) tick();
    chk("rst_new_count", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) begin
      chk("rst_new_source", 64'(obs[0].src), 64'hB);
      chk("rst_new_data", obs[0].data, 64'h408);
    end

    // Random traffic against the model
    rnd_done = 0;
    fork
      begin
        for (int t = 0; t < 60; t++) begin
          r_op   = 3'($urandom_range(0, 7));
          r_size = 3'($urandom_range(0, 7));
          send_req(r_op, r_size, 4'($urandom), $urandom);
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          d_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    d_ready = 1;
    for (int k = 0; k < 2000 && q.size() != 0; k++) tick();
    chk("rnd_drained", 64'(q.size()), 64'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
